// File: rtl/mod_exp.sv
// rtl/mod_exp.sv - fixed-latency modular exponentiation (left-to-right square-and-multiply)
module mod_exp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             modexp_ready,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             modexp_done,
  output logic             modexp_error
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, REDUCE, SQR, MUL, DONE} state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] dvd;      // dividend shifted out MSB first during REDUCE
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] mod_q;
  logic [WIDTH-1:0] a_q;      // base mod n
  logic [WIDTH-1:0] p_q;      // running accumulator
  logic [WIDTH:0]   r_q;      // partial remainder / interleaved product
  logic [CW-1:0]    cnt;      // step counter inside a phase
  logic [CW-2:0]    exp_idx;  // exponent bit being processed
  logic [CW-2:0]    bit_idx;

  logic [WIDTH:0]   mod_ext, r_sh, r_a, r_b, r_next, d_sh, d_next;
  logic [WIDTH-1:0] my;
  logic             ybit, mod_small, last_mul, cur_bit;

  // Shared arithmetic: one interleaved multiply step and one restoring-division step
  always_comb begin
    mod_ext   = {1'b0, mod_q};
    mod_small = (mod_q[WIDTH-1:1] == '0);
    last_mul  = (cnt == CW'(WIDTH - 1));
    cur_bit   = exp_q[exp_idx];
    bit_idx   = (CW-1)'(WIDTH - 1) - cnt[CW-2:0];
    my        = (state == SQR) ? p_q : a_q;
    ybit      = my[bit_idx];
    r_sh      = r_q << 1;
    r_a       = (r_sh >= mod_ext) ? r_sh - mod_ext : r_sh;
    r_b       = ybit ? r_a + {1'b0, p_q} : r_a;
    r_next    = (r_b >= mod_ext) ? r_b - mod_ext : r_b;
    d_sh      = (r_q << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};
    d_next    = (d_sh >= mod_ext) ? d_sh - mod_ext : d_sh;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (modexp_ready) state_n = REDUCE;
      REDUCE: begin
        if (cnt == '0 && mod_small)      state_n = DONE;
        else if (cnt == CW'(WIDTH))      state_n = SQR;
      end
      SQR:    if (last_mul) state_n = MUL;
      MUL: begin
        if (last_mul && exp_idx == '0)   state_n = DONE;
        else if (last_mul)               state_n = SQR;
      end
      DONE:   if (!modexp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand latch, reduction, square/multiply passes, result update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd          <= '0;
      exp_q        <= '0;
      mod_q        <= '0;
      a_q          <= '0;
      p_q          <= '0;
      r_q          <= '0;
      cnt          <= '0;
      exp_idx      <= '0;
      result       <= '0;
      modexp_done  <= 1'b0;
      modexp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (modexp_ready) begin
            dvd          <= base;
            exp_q        <= exponent;
            mod_q        <= modulus;
            modexp_done  <= 1'b0;
            modexp_error <= 1'b0;
            cnt          <= '0;
          end
        end
        REDUCE: begin
          if (cnt == '0) begin
            // decision cycle: degenerate moduli finish here
            r_q <= '0;
            cnt <= cnt + 1'b1;
            if (mod_small) begin
              result       <= '0;
              modexp_error <= (mod_q == '0);
              modexp_done  <= 1'b1;
            end
          end else begin
            r_q <= d_next;
            dvd <= dvd << 1;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH)) begin
              a_q     <= d_next[WIDTH-1:0];
              r_q     <= '0;
              cnt     <= '0;
              p_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
              exp_idx <= (CW-1)'(WIDTH - 1);
            end
          end
        end
        SQR: begin
          r_q <= r_next;
          cnt <= cnt + 1'b1;
          if (last_mul) begin
            p_q <= r_next[WIDTH-1:0];
            r_q <= '0;
            cnt <= '0;
          end
        end
        MUL: begin
          r_q <= r_next;
          cnt <= cnt + 1'b1;
          if (last_mul) begin
            r_q <= '0;
            cnt <= '0;
            if (cur_bit) p_q <= r_next[WIDTH-1:0];
            if (exp_idx == '0) begin
              result      <= cur_bit ? r_next[WIDTH-1:0] : p_q;
              modexp_done <= 1'b1;
            end else begin
              exp_idx <= exp_idx - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp.sv
// tb/tb_mod_exp.sv - scoreboard bench for mod_exp
module tb_mod_exp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        modexp_ready = 1'b0;
  logic [31:0] base = '0, exponent = '0, modulus = '0;
  logic [31:0] result;
  logic        modexp_done, modexp_error;

  mod_exp #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .modexp_ready(modexp_ready),
    .base(base), .exponent(exponent), .modulus(modulus),
    .result(result), .modexp_done(modexp_done), .modexp_error(modexp_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          k_edge;
  logic [31:0] old_result;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    longint unsigned r, x, mm;
    if (m == 0) return 32'd0;
    mm = 64'(m);
    x  = 64'(b) % mm;
    r  = 1;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * x) % mm;
    end
    return r[31:0];
  endfunction

  // Drive a start; when push is set, record the expected outcome.
  task automatic start(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                       input logic [31:0] expv, input bit push, input bit hold);
    exp_t t;
    @(negedge clk);
    base = b; exponent = e; modulus = m;
    modexp_ready = 1'b1;
    old_result = result;
    @(posedge clk);
    #1;
    k_edge = cyc;
    if (push) begin
      t.res = expv;
      t.err = (m == 0);
      t.lat = (m < 2) ? 1 : 2081;
      sb.push_back(t);
    end
    if (!hold) begin
      @(negedge clk);
      modexp_ready = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    exp_t t;
    bit   seen = 0;
    bit   changed = 0;
    int   lat = -1;
    for (int i = 0; i < 2300; i++) begin
      @(negedge clk);
      if (modexp_done) begin
        seen = 1;
        lat = cyc - k_edge;
        break;
      end
      if (result !== old_result) changed = 1;
    end
    if (!seen) check({tag, "_timeout"}, 64'(seen), 64'd1);
    t = sb.pop_front();
    check({tag, "_result"}, 64'(result), 64'(t.res));
    check({tag, "_error"}, 64'(modexp_error), 64'(t.err));
    check({tag, "_latency"}, 64'(lat), 64'(t.lat));
    check({tag, "_no_intermediate"}, 64'(changed), 64'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] b, input logic [31:0] e,
                     input logic [31:0] m, input logic [31:0] expv);
    start(b, e, m, expv, 1'b1, 1'b0);
    wait_done(tag);
  endtask

  initial begin
    logic [31:0] rb, re, rm;

    repeat (2) @(negedge clk);
    check("reset_result", 64'(result), 64'd0);
    check("reset_done", 64'(modexp_done), 64'd0);
    check("reset_error", 64'(modexp_error), 64'd0);
    reset = 1'b0;

    run("v4_13_497", 32'd4, 32'd13, 32'd497, 32'd445);
    run("v556_1_27", 32'd556, 32'd1, 32'd27, 32'd16);
    run("v234328_1_273", 32'd234328, 32'd1, 32'd273, 32'd94);
    run("exp0", 32'd5, 32'd0, 32'd13, 32'd1);
    run("mod1", 32'd7, 32'd5, 32'd1, 32'd0);
    run("mod0", 32'd9, 32'd4, 32'd0, 32'd0);
    run("after_err", 32'd5, 32'd3, 32'd13, 32'd8);
    run("base0", 32'd0, 32'd9, 32'd13, 32'd0);

    // abort a run with reset after 1000 cycles
    start(32'd4, 32'd13, 32'd497, 32'd0, 1'b0, 1'b0);
    repeat (1000) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_result", 64'(result), 64'd0);
    check("midreset_done", 64'(modexp_done), 64'd0);
    check("midreset_error", 64'(modexp_error), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ready held high through DONE: exactly one operation
    start(32'd2, 32'd10, 32'd1000, 32'd24, 1'b1, 1'b1);
    wait_done("held");
    repeat (100) @(negedge clk);
    check("held_done_stays", 64'(modexp_done), 64'd1);
    check("held_result_stays", 64'(result), 64'd24);
    modexp_ready = 1'b0;
    @(negedge clk);

    // inputs and ready disturbed while busy
    start(32'd3, 32'd7, 32'd11, 32'd9, 1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      base = $urandom; exponent = $urandom; modulus = $urandom;
      modexp_ready = $urandom_range(0, 1) == 1;
    end
    modexp_ready = 1'b0;
    wait_done("disturbed");

    // random operands, including moduli with the top bit set
    for (int i = 0; i < 3; i++) begin
      rb = $urandom; re = $urandom;
      rm = (i == 0) ? ($urandom | 32'h8000_0001) : ($urandom_range(2, 100000));
      run($sformatf("rand%0d", i), rb, re, rm, model(rb, re, rm));
    end
    run("max_mod", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB,
        model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
